// File: rtl/cache_nway_pkg.sv
// Shared definitions for the N-way set-associative cache: default geometry,
// invalidate-all FSM states and the write-hit byte merge.
package cache_nway_pkg;

  localparam int OFFSET_WIDTH_DEF = 3;
  localparam int INDEX_WIDTH_DEF  = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_nway_if.sv
// Controller-facing request/response bundle of the N-way cache datapath.
interface cache_nway_if
  import cache_nway_pkg::*;
#(
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter int INDEX_WIDTH  = INDEX_WIDTH_DEF,
  parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH,
  parameter int WAYS         = 4
);
  localparam int BLOCK_SIZE = 1 << OFFSET_WIDTH;
  localparam int WAY_WIDTH  = $clog2(WAYS);

  logic                        enable;
  logic                        cmp;
  logic                        write;
  logic [3:0]                  byte_w_en;
  logic                        valid_in;
  logic [TAG_WIDTH-1:0]        tag_in;
  logic [INDEX_WIDTH-1:0]      index;
  logic [OFFSET_WIDTH-1:0]     word_sel;
  logic [31:0]                 data_in;
  logic [32*BLOCK_SIZE-1:0]    data_block_in;
  logic                        inv_all;
  logic                        hit;
  logic [WAY_WIDTH-1:0]        hit_way;
  logic                        dirty;
  logic                        valid_out;
  logic [TAG_WIDTH-1:0]        tag_out;
  logic [31:0]                 data_out;
  logic [32*BLOCK_SIZE-1:0]    data_wb;
  logic [WAY_WIDTH-1:0]        victim_way;
  logic                        busy;

  modport master (
    output enable, cmp, write, byte_w_en, valid_in, tag_in, index, word_sel,
           data_in, data_block_in, inv_all,
    input  hit, hit_way, dirty, valid_out, tag_out, data_out, data_wb,
           victim_way, busy
  );

  modport slave (
    input  enable, cmp, write, byte_w_en, valid_in, tag_in, index, word_sel,
           data_in, data_block_in, inv_all,
    output hit, hit_way, dirty, valid_out, tag_out, data_out, data_wb,
           victim_way, busy
  );

endinterface

// File: rtl/cache_nway_plru.sv
// Tree pseudo-LRU for one set: heap-ordered node bits, 0 = go left.
// Produces the victim leaf and the bits after touching access_way.
module cache_nway_plru #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]          bits,
  input  logic [$clog2(WAYS)-1:0]  access_way,
  output logic [$clog2(WAYS)-1:0]  victim,
  output logic [WAYS-2:0]          next_bits
);
  localparam int WAY_WIDTH = $clog2(WAYS);

  logic [WAY_WIDTH-1:0] node_v;
  logic [WAY_WIDTH-1:0] node_u;
  logic [WAY_WIDTH-1:0] path_u;
  logic                 dir_v;
  logic                 dir_u;

  always_comb begin
    node_v = '0;
    dir_v  = 1'b0;
    victim = '0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      dir_v  = bits[node_v];
      victim = (victim << 1) | WAY_WIDTH'(dir_v);
      node_v = (node_v << 1) + WAY_WIDTH'(1) + WAY_WIDTH'(dir_v);
    end
  end

  // Walk the accessed way's path MSB first, pointing every node the other way.
  always_comb begin
    next_bits = bits;
    node_u    = '0;
    dir_u     = 1'b0;
    path_u    = access_way;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      dir_u             = path_u[WAY_WIDTH-1];
      next_bits[node_u] = ~dir_u;
      node_u            = (node_u << 1) + WAY_WIDTH'(1) + WAY_WIDTH'(dir_u);
      path_u            = path_u << 1;
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative cache datapath: tag compare, byte-merged write hits,
// PLRU victim latch for write-back/fill, and a one-set-per-cycle invalidate-all.
module cache_nway
  import cache_nway_pkg::*;
#(
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter int INDEX_WIDTH  = INDEX_WIDTH_DEF,
  parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH,
  parameter int WAYS         = 4
) (
  input logic         clk,
  input logic         rst,
  cache_nway_if.slave bus
);
  localparam int BLOCK_SIZE  = 1 << OFFSET_WIDTH;
  localparam int CACHE_DEPTH = 1 << INDEX_WIDTH;
  localparam int WAY_WIDTH   = $clog2(WAYS);
  localparam int LINE_W      = 32 * BLOCK_SIZE;

  logic [TAG_WIDTH-1:0]   tag_mem  [WAYS][CACHE_DEPTH];
  logic [LINE_W-1:0]      data_mem [WAYS][CACHE_DEPTH];
  logic [CACHE_DEPTH-1:0] valid_q  [WAYS];
  logic [CACHE_DEPTH-1:0] dirty_q  [WAYS];
  logic [WAYS-2:0]        plru_q   [CACHE_DEPTH];
  logic [WAY_WIDTH-1:0]   victim_ff;
  logic [INDEX_WIDTH-1:0] set_cnt;
  state_t                 state, state_nxt;

  logic                 busy_c, lookup, fill, any_hit, any_valid, has_invalid;
  logic [WAYS-1:0]      hit_vec, valid_vec, dirty_vec;
  logic [WAY_WIDTH-1:0] hit_way_c, free_way, plru_victim, miss_victim, plru_access;
  logic [WAYS-2:0]      plru_next;
  logic [LINE_W-1:0]    hit_line;
  logic [31:0]          hit_word;

  // Reverse scan leaves the lowest matching / lowest free way selected.
  always_comb begin
    hit_vec   = '0;
    valid_vec = '0;
    dirty_vec = '0;
    hit_way_c = '0;
    free_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      valid_vec[w] = valid_q[w][bus.index];
      dirty_vec[w] = dirty_q[w][bus.index];
      hit_vec[w]   = valid_vec[w] && (tag_mem[w][bus.index] == bus.tag_in);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w])    hit_way_c = WAY_WIDTH'(w);
      if (!valid_vec[w]) free_way  = WAY_WIDTH'(w);
    end
  end

  assign any_hit     = |hit_vec;
  assign any_valid   = |valid_vec;
  assign has_invalid = ~&valid_vec;
  assign miss_victim = has_invalid ? free_way : plru_victim;
  assign busy_c      = (state == FLUSH);
  assign lookup      = bus.enable & bus.cmp & ~busy_c;
  assign fill        = bus.enable & ~bus.cmp & bus.write & ~busy_c;
  assign plru_access = bus.cmp ? hit_way_c : victim_ff;
  assign hit_line    = data_mem[hit_way_c][bus.index];
  assign hit_word    = hit_line[{bus.word_sel, 5'b0} +: 32];

  cache_nway_plru #(.WAYS(WAYS)) u_plru (
    .bits       (plru_q[bus.index]),
    .access_way (plru_access),
    .victim     (plru_victim),
    .next_bits  (plru_next)
  );

  assign bus.hit        = bus.cmp & ~busy_c & any_hit;
  assign bus.hit_way    = hit_way_c;
  assign bus.data_out   = hit_word;
  assign bus.valid_out  = ~busy_c & any_valid;
  assign bus.dirty      = ~busy_c & (bus.cmp
                          ? (~any_hit & valid_vec[miss_victim] & dirty_vec[miss_victim])
                          : (valid_vec[victim_ff] & dirty_vec[victim_ff]));
  assign bus.tag_out    = bus.cmp ? '0 : tag_mem[victim_ff][bus.index];
  assign bus.data_wb    = bus.cmp ? '0 : data_mem[victim_ff][bus.index];
  assign bus.victim_way = bus.cmp ? miss_victim : victim_ff;
  assign bus.busy       = busy_c;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.inv_all) state_nxt = FLUSH;
      FLUSH: if (set_cnt == INDEX_WIDTH'(CACHE_DEPTH - 1)) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      set_cnt   <= '0;
      victim_ff <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < CACHE_DEPTH; s++) plru_q[s] <= '0;
    end else begin
      state <= state_nxt;
      if (busy_c) begin
        set_cnt <= set_cnt + 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][set_cnt] <= 1'b0;
          dirty_q[w][set_cnt] <= 1'b0;
        end
        plru_q[set_cnt] <= '0;
      end else begin
        if (bus.inv_all) set_cnt <= '0;
        if (lookup && any_hit) begin
          plru_q[bus.index] <= plru_next;
          if (bus.write) dirty_q[hit_way_c][bus.index] <= 1'b1;
        end
        if (lookup && !any_hit) victim_ff <= miss_victim;
        if (fill) begin
          valid_q[victim_ff][bus.index] <= bus.valid_in;
          dirty_q[victim_ff][bus.index] <= 1'b0;
          plru_q[bus.index]             <= plru_next;
        end
      end
    end
  end

  // Tag/data arrays carry no reset; validity alone decides what is live.
  always_ff @(posedge clk) begin
    if (lookup && any_hit && bus.write)
      data_mem[hit_way_c][bus.index][{bus.word_sel, 5'b0} +: 32] <=
        byte_merge(hit_word, bus.data_in, bus.byte_w_en);
    if (fill) begin
      data_mem[victim_ff][bus.index] <= bus.data_block_in;
      tag_mem[victim_ff][bus.index]  <= bus.tag_in;
    end
  end

endmodule

// File: tb/tb_cache_nway.sv
// Randomised and directed bench for cache_nway (WAYS=4) against a set/way
// array model with an explicit three-node PLRU tree per set.
module tb_cache_nway;
  localparam int OW = 3, IW = 6, TW = 21, NW = 4, DEPTH = 64, BS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_nway_if #(.OFFSET_WIDTH(OW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW), .WAYS(NW)) bus ();
  cache_nway #(.OFFSET_WIDTH(OW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW), .WAYS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference state
  bit              rv    [NW][DEPTH];
  bit              rd    [NW][DEPTH];
  bit              known [NW][DEPTH];
  logic [TW-1:0]   rt    [NW][DEPTH];
  logic [31:0]     rdat  [NW][DEPTH][BS];
  bit   [2:0]      rp    [DEPTH];
  int              vff;
  int              flush_left;

  logic            o_hit, o_dirty, o_busy, o_valid;
  logic [1:0]      o_hw, o_vw;
  logic [31:0]     o_dout;
  logic [TW-1:0]   o_tag;

  // p[0]: 0 = victim among ways 0/1; p[1]: 0 -> way0 else way1; p[2]: 0 -> way2 else way3
  function automatic int plru_pick(input bit [2:0] p);
    if (!p[0]) return p[1] ? 1 : 0;
    return p[2] ? 3 : 2;
  endfunction

  task automatic touch(input int s, input int w);
    bit [2:0] p;
    p = rp[s];
    p[0] = (w < 2);
    if (w < 2) p[1] = (w == 0);
    else       p[2] = (w == 2);
    rp[s] = p;
  endtask

  function automatic logic [255:0] line_of(input int w, input int s);
    logic [255:0] l;
    for (int k = 0; k < BS; k++) l[32*k +: 32] = rdat[w][s][k];
    return l;
  endfunction

  function automatic logic [255:0] rand_blk();
    logic [255:0] b;
    for (int k = 0; k < BS; k++) b[32*k +: 32] = $urandom;
    return b;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < DEPTH; s++) begin
        rv[w][s] = 1'b0;
        rd[w][s] = 1'b0;
      end
    for (int s = 0; s < DEPTH; s++) rp[s] = 3'b000;
    vff        = 0;
    flush_left = 0;
  endtask

  task automatic req(input bit en, input bit cm, input bit wr, input logic [3:0] be,
                     input bit vin, input logic [TW-1:0] tg, input int ix, input int ws,
                     input logic [31:0] din, input logic [255:0] blk, input bit inv);
    int fh, fv, vict, s;
    bit busy_e, anyv;
    logic [31:0] wd;
    @(negedge clk);
    bus.enable        = en;
    bus.cmp           = cm;
    bus.write         = wr;
    bus.byte_w_en     = be;
    bus.valid_in      = vin;
    bus.tag_in        = tg;
    bus.index         = IW'(ix);
    bus.word_sel      = OW'(ws);
    bus.data_in       = din;
    bus.data_block_in = blk;
    bus.inv_all       = inv;
    #1;
    o_hit = bus.hit;  o_dirty = bus.dirty; o_busy = bus.busy; o_valid = bus.valid_out;
    o_hw  = bus.hit_way; o_vw = bus.victim_way; o_dout = bus.data_out; o_tag = bus.tag_out;

    busy_e = (flush_left > 0);
    fh = -1; fv = -1; anyv = 1'b0;
    for (int w = NW - 1; w >= 0; w--) begin
      if (rv[w][ix] && rt[w][ix] == tg) fh = w;
      if (!rv[w][ix]) fv = w;
      anyv |= rv[w][ix];
    end
    vict = (fv >= 0) ? fv : plru_pick(rp[ix]);

    check("busy", 256'(bus.busy), 256'(busy_e));
    if (busy_e) begin
      check("hit_busy", 256'(bus.hit), 256'(0));
      check("valid_out_busy", 256'(bus.valid_out), 256'(0));
      check("dirty_busy", 256'(bus.dirty), 256'(0));
    end else begin
      check("hit", 256'(bus.hit), 256'(cm && fh >= 0));
      if (cm && fh >= 0) begin
        check("hit_way", 256'(bus.hit_way), 256'(fh));
        check("data_out", 256'(bus.data_out), 256'(rdat[fh][ix][ws]));
      end
      check("valid_out", 256'(bus.valid_out), 256'(anyv));
      if (cm) begin
        check("dirty_miss", 256'(bus.dirty), 256'(fh < 0 && rv[vict][ix] && rd[vict][ix]));
        check("victim_way", 256'(bus.victim_way), 256'(vict));
        check("tag_out_zero", 256'(bus.tag_out), 256'(0));
        check("data_wb_zero", bus.data_wb, 256'(0));
      end else begin
        check("dirty_vff", 256'(bus.dirty), 256'(rv[vff][ix] && rd[vff][ix]));
        check("victim_vff", 256'(bus.victim_way), 256'(vff));
        if (known[vff][ix]) begin
          check("tag_out", 256'(bus.tag_out), 256'(rt[vff][ix]));
          check("data_wb", bus.data_wb, line_of(vff, ix));
        end
      end
    end

    if (busy_e) begin
      s = DEPTH - flush_left;
      for (int w = 0; w < NW; w++) begin
        rv[w][s] = 1'b0;
        rd[w][s] = 1'b0;
      end
      rp[s] = 3'b000;
      flush_left--;
    end else begin
      if (en && cm) begin
        if (fh >= 0) begin
          if (wr) begin
            wd = rdat[fh][ix][ws];
            for (int b = 0; b < 4; b++) if (be[b]) wd[8*b +: 8] = din[8*b +: 8];
            rdat[fh][ix][ws] = wd;
            rd[fh][ix] = 1'b1;
          end
          touch(ix, fh);
        end else begin
          vff = vict;
        end
      end
      if (en && !cm && wr) begin
        rt[vff][ix] = tg;
        for (int k = 0; k < BS; k++) rdat[vff][ix][k] = blk[32*k +: 32];
        rv[vff][ix]    = vin;
        rd[vff][ix]    = 1'b0;
        known[vff][ix] = 1'b1;
        touch(ix, vff);
      end
      if (inv) flush_left = DEPTH;
    end
  endtask

  task automatic lookup(input logic [TW-1:0] tg, input int ix, input int ws);
    req(1, 1, 0, 4'h0, 0, tg, ix, ws, 32'h0, 256'h0, 0);
  endtask
  task automatic lookup_wr(input logic [TW-1:0] tg, input int ix, input int ws,
                           input logic [31:0] din, input logic [3:0] be);
    req(1, 1, 1, be, 0, tg, ix, ws, din, 256'h0, 0);
  endtask
  task automatic fill(input logic [TW-1:0] tg, input int ix, input logic [255:0] blk);
    req(1, 0, 1, 4'h0, 1, tg, ix, 0, 32'h0, blk, 0);
  endtask
  task automatic wb_read(input int ix);
    req(1, 0, 0, 4'h0, 0, '0, ix, 0, 32'h0, 256'h0, 0);
  endtask
  task automatic idle(input bit inv);
    req(0, 0, 0, 4'h0, 0, '0, 0, 0, 32'h0, 256'h0, inv);
  endtask
  task automatic miss_fill(input logic [TW-1:0] tg, input int ix, input logic [255:0] blk);
    lookup(tg, ix, 0);
    fill(tg, ix, blk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] blk;
    int cnt, r;
    rst = 1'b1;
    bus.enable = 0; bus.cmp = 0; bus.write = 0; bus.byte_w_en = 0; bus.valid_in = 0;
    bus.tag_in = 0; bus.index = 0; bus.word_sel = 0; bus.data_in = 0;
    bus.data_block_in = 0; bus.inv_all = 0;
    model_reset();
    for (int w = 0; w < NW; w++) for (int s = 0; s < DEPTH; s++) known[w][s] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state and first fill
    lookup(21'h1234, 5, 0);
    check("t1_hit", 256'(o_hit), 256'(0));
    check("t1_victim", 256'(o_vw), 256'(0));
    check("t1_dirty", 256'(o_dirty), 256'(0));
    check("t1_busy", 256'(o_busy), 256'(0));
    for (int k = 0; k < BS; k++) blk[32*k +: 32] = k;
    fill(21'h1234, 5, blk);
    lookup(21'h1234, 5, 3);
    check("t1_hit_after", 256'(o_hit), 256'(1));
    check("t1_hit_way", 256'(o_hw), 256'(0));
    check("t1_data", 256'(o_dout), 256'(3));

    // PLRU victim after touching ways 0 and 2
    for (int w = 0; w < NW; w++) miss_fill(TW'(32'h100 + w), 9, rand_blk());
    lookup(21'h100, 9, 0);
    lookup(21'h102, 9, 0);
    lookup(21'h104, 9, 0);
    check("t2_victim", 256'(o_vw), 256'(1));
    fill(21'h104, 9, rand_blk());
    lookup(21'h101, 9, 0);
    check("t2_b_miss", 256'(o_hit), 256'(0));

    // Byte-merged write hit, then dirty victim write-back
    blk = rand_blk();
    blk[31:0] = 32'h11223344;
    miss_fill(21'h55, 12, blk);
    lookup_wr(21'h55, 12, 0, 32'hDEADBEEF, 4'b0011);
    lookup(21'h55, 12, 0);
    check("t3_merge", 256'(o_dout), 256'(32'h1122BEEF));
    for (int w = 1; w < NW; w++) miss_fill(TW'(32'h60 + w), 12, rand_blk());
    lookup(21'h99, 12, 0);
    check("t3_victim", 256'(o_vw), 256'(0));
    check("t3_dirty", 256'(o_dirty), 256'(1));
    wb_read(12);
    check("t3_tag_out", 256'(o_tag), 256'(21'h55));
    check("t3_wb_dirty", 256'(o_dirty), 256'(1));

    // Write miss leaves storage untouched
    lookup_wr(21'h77, 12, 2, 32'hFFFFFFFF, 4'hF);
    check("t4_wmiss_hit", 256'(o_hit), 256'(0));
    lookup(21'h77, 12, 2);
    check("t4_still_miss", 256'(o_hit), 256'(0));

    // Invalidate-all with lookups presented while busy
    idle(1);
    cnt = 0;
    for (int i = 0; i < 70; i++) begin
      lookup(21'h1234, 5, 3);
      if (o_busy) cnt++;
    end
    check("t5_busy_len", 256'(cnt), 256'(64));
    lookup(21'h1234, 5, 3);
    check("t5_miss_a", 256'(o_hit), 256'(0));
    lookup(21'h103, 9, 0);
    check("t5_miss_b", 256'(o_hit), 256'(0));
    check("t5_victim", 256'(o_vw), 256'(0));
    lookup(21'h55, 12, 0);
    check("t5_miss_c", 256'(o_hit), 256'(0));

    // Reset in the middle of a flush
    miss_fill(21'h321, 3, rand_blk());
    miss_fill(21'h322, 40, rand_blk());
    idle(1);
    repeat (20) idle(0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_busy_rst", 256'(bus.busy), 256'(0));
    check("t6_valid_rst", 256'(bus.valid_out), 256'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < DEPTH; s++) lookup(21'h321, s, 0);
    lookup(21'h322, 40, 0);
    check("t6_set40_invalid", 256'(o_valid), 256'(0));
    miss_fill(21'h321, 3, rand_blk());
    lookup(21'h321, 3, 5);
    check("t6_hit_after", 256'(o_hit), 256'(1));

    // Randomised traffic over a few hot sets and tags
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)
        req(1, 1, ($urandom_range(0, 3) == 0), 4'($urandom), 0, TW'($urandom_range(0, 5)),
            $urandom_range(0, 3), $urandom_range(0, BS - 1), $urandom, 256'h0, 0);
      else if (r < 60)
        req(1, 0, 1, 4'h0, ($urandom_range(0, 7) != 0), TW'($urandom_range(0, 5)),
            $urandom_range(0, 3), 0, 32'h0, rand_blk(), 0);
      else if (r < 70)
        wb_read($urandom_range(0, 3));
      else if (r < 99)
        req(0, ($urandom_range(0, 1) == 1), 0, 4'h0, 0, TW'($urandom_range(0, 5)),
            $urandom_range(0, 3), $urandom_range(0, BS - 1), 32'h0, 256'h0, 0);
      else
        idle(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
